// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register decoder and its register bank.
// Build option SPI_REG_SHADOW_EN selects atomic (shadowed) register updates.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    localparam int         CMD_WRITE_BIT = 7;
    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == ERR_COUNT_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// Control register bank: live registers plus optional shadow bank/dirty mask.
// With SPI_REG_SHADOW_EN defined, writes are staged and committed atomically per message.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter  int NREGS  = 16,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 commit,
    input  logic                 discard,
    output logic [8*NREGS-1:0]   regs_flat
);

    logic [NREGS-1:0][7:0] live_q;
    logic [NREGS-1:0][7:0] live_d;

`ifdef SPI_REG_SHADOW_EN
    logic [NREGS-1:0][7:0] shadow_q;
    logic [NREGS-1:0][7:0] shadow_d;
    logic [NREGS-1:0]      dirty_q;
    logic [NREGS-1:0]      dirty_d;

    // Staging, commit and discard; a write arriving with commit is merged into the commit.
    always_comb begin
        live_d   = live_q;
        shadow_d = shadow_q;
        dirty_d  = dirty_q;
        if (discard) begin
            dirty_d = {NREGS{1'b0}};
        end else if (commit) begin
            for (int i = 0; i < NREGS; i++) begin
                if (dirty_q[i]) begin
                    live_d[i] = shadow_q[i];
                end else begin
                    live_d[i] = live_q[i];
                end
            end
            if (wr_en) begin
                live_d[wr_addr] = wr_data;
            end else begin
                live_d[wr_addr] = live_d[wr_addr];
            end
            dirty_d = {NREGS{1'b0}};
        end else if (wr_en) begin
            shadow_d[wr_addr] = wr_data;
            dirty_d[wr_addr]  = 1'b1;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Shadow bank and dirty mask state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= {NREGS{8'h00}};
            dirty_q  <= {NREGS{1'b0}};
        end else begin
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
        end
    end
`else
    logic unused_ctrl;
    assign unused_ctrl = commit | discard;

    // Direct write into the live registers.
    always_comb begin
        live_d = live_q;
        if (wr_en) begin
            live_d[wr_addr] = wr_data;
        end else begin
            live_d = live_q;
        end
    end
`endif

    // Live register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= {NREGS{8'h00}};
        end else begin
            live_q <= live_d;
        end
    end

    assign regs_flat = live_q;

endmodule

// File: rtl/spi_reg_decoder.sv
// Turns SPI message byte streams into auto-incrementing writes to a control register bank.
// Define SPI_REG_SHADOW_EN for per-message atomic register updates.
module spi_reg_decoder
    import spi_reg_pkg::*;
#(
    parameter  int NREGS  = 16,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 msg_start,
    input  logic                 msg_end,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_corrupt,
    output logic [8*NREGS-1:0]   regs_flat,
    output logic                 msg_ok,
    output logic                 msg_err,
    output logic [7:0]           err_count
);

    localparam logic [7:0]    NREGS_B  = 8'(NREGS);
    localparam logic [ADDR_W:0] ADDR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    // One extra bit so that "one past the last register" is representable.
    logic [ADDR_W:0]     addr_q, addr_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                msg_ok_q, msg_ok_d;
    logic                msg_err_q, msg_err_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                commit_s;
    logic                discard_s;

    // Message FSM, address counter, overflow flag and error accounting.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ovf_d     = ovf_q;
        err_cnt_d = err_cnt_q;
        msg_ok_d  = 1'b0;
        msg_err_d = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        commit_s  = 1'b0;
        discard_s = 1'b0;
        if (msg_start) begin
            if (state_q != ST_IDLE) begin
                msg_err_d = 1'b1;
                err_cnt_d = sat_inc(err_cnt_q);
                discard_s = 1'b1;
            end else begin
                discard_s = 1'b0;
            end
            state_d = ST_CMD;
            addr_d  = {(ADDR_W+1){1'b0}};
            ovf_d   = 1'b0;
        end else if (msg_end) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                ovf_d   = 1'b0;
                if ((state_q == ST_DATA) && !rx_corrupt && !ovf_q) begin
                    msg_ok_d = 1'b1;
                    commit_s = 1'b1;
                end else begin
                    msg_err_d = 1'b1;
                    err_cnt_d = sat_inc(err_cnt_q);
                    discard_s = 1'b1;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else if (rx_valid) begin
            case (state_q)
                ST_CMD: begin
                    if (rx_data[CMD_WRITE_BIT] && ({1'b0, rx_data[6:0]} < NREGS_B)) begin
                        addr_d  = {1'b0, rx_data[ADDR_W-1:0]};
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (addr_q[ADDR_W]) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q[ADDR_W-1:0];
                        wr_data_d = rx_data;
                        addr_d    = addr_q + ADDR_ONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Control state and the registered write stage feeding the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= {(ADDR_W+1){1'b0}};
            ovf_q     <= 1'b0;
            err_cnt_q <= 8'h00;
            msg_ok_q  <= 1'b0;
            msg_err_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ovf_q     <= ovf_d;
            err_cnt_q <= err_cnt_d;
            msg_ok_q  <= msg_ok_d;
            msg_err_q <= msg_err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    spi_reg_bank #(
        .NREGS (NREGS)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en_q),
        .wr_addr   (wr_addr_q),
        .wr_data   (wr_data_q),
        .commit    (commit_s),
        .discard   (discard_s),
        .regs_flat (regs_flat)
    );

    assign msg_ok    = msg_ok_q;
    assign msg_err   = msg_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_spi_reg_decoder.sv
// Self-checking bench for spi_reg_decoder: message-level reference model plus directed scenarios.
// Expectations follow SPI_REG_SHADOW_EN when it is defined for the build.
module tb_spi_reg_decoder;

    localparam int NREGS = 16;
    localparam int FW    = 8 * NREGS;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          msg_start  = 1'b0;
    logic          msg_end    = 1'b0;
    logic [7:0]    rx_data    = 8'h00;
    logic          rx_valid   = 1'b0;
    logic          rx_corrupt = 1'b0;
    logic [FW-1:0] regs_flat;
    logic          msg_ok;
    logic          msg_err;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    spi_reg_decoder #(.NREGS(NREGS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .msg_start  (msg_start),
        .msg_end    (msg_end),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_corrupt (rx_corrupt),
        .regs_flat  (regs_flat),
        .msg_ok     (msg_ok),
        .msg_err    (msg_err),
        .err_count  (err_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: message-level view of the byte stream
    logic [7:0] exp_regs [NREGS];
    logic [7:0] stage    [NREGS];
    bit         in_msg;
    int         nbytes;
    logic [7:0] cmd;
    bit         pend_v;
    int         pend_a;
    logic [7:0] pend_d;
    bit         exp_ok;
    bit         exp_err;
    int         exp_cnt;
    int         ok_seen  = 0;
    int         err_seen = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return regs_flat[8*i +: 8];
    endfunction

    function automatic bit cmd_ok();
        return cmd[7] && (int'(cmd[6:0]) < NREGS);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            exp_regs[i] = 8'h00;
            stage[i]    = 8'h00;
        end
        in_msg  = 1'b0;
        nbytes  = 0;
        cmd     = 8'h00;
        pend_v  = 1'b0;
        exp_ok  = 1'b0;
        exp_err = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic model_fail();
        exp_err = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
    endtask

    task automatic model_step();
        int base;
        int ndata;
        exp_ok  = 1'b0;
        exp_err = 1'b0;
        if (pend_v) begin
            exp_regs[pend_a] = pend_d;
            pend_v = 1'b0;
        end
        if (msg_start) begin
            if (in_msg) model_fail();
            in_msg = 1'b1;
            nbytes = 0;
            for (int i = 0; i < NREGS; i++) stage[i] = 8'hxx;
        end else if (msg_end) begin
            if (in_msg) begin
                base  = int'(cmd[6:0]);
                ndata = nbytes - 1;
                if (nbytes >= 1 && cmd_ok() && ndata <= NREGS - base && !rx_corrupt) begin
                    exp_ok = 1'b1;
`ifdef SPI_REG_SHADOW_EN
                    for (int i = 0; i < NREGS; i++)
                        if (!$isunknown(stage[i])) exp_regs[i] = stage[i];
`endif
                end else begin
                    model_fail();
                end
                in_msg = 1'b0;
            end
        end else if (rx_valid && in_msg) begin
            if (nbytes == 0) begin
                cmd = rx_data;
            end else if (cmd_ok() && (nbytes - 1) < NREGS - int'(cmd[6:0])) begin
`ifdef SPI_REG_SHADOW_EN
                stage[int'(cmd[6:0]) + nbytes - 1] = rx_data;
`else
                pend_v = 1'b1;
                pend_a = int'(cmd[6:0]) + nbytes - 1;
                pend_d = rx_data;
`endif
            end
            nbytes++;
        end
    endtask

    task automatic compare_all();
        logic [FW-1:0] exp_flat;
        for (int i = 0; i < NREGS; i++) exp_flat[8*i +: 8] = exp_regs[i];
        check("regs_flat", regs_flat, exp_flat);
        check("msg_ok", FW'(msg_ok), FW'(exp_ok));
        check("msg_err", FW'(msg_err), FW'(exp_err));
        check("err_count", FW'(err_count), FW'(exp_cnt[7:0]));
        if (msg_ok)  ok_seen++;
        if (msg_err) err_seen++;
    endtask

    // Model advances on each rising edge; outputs compared on the falling edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step();
            @(negedge clk);
            if (!rst_n) model_reset();
            compare_all();
        end
    end

    task automatic cyc(input bit s, input bit e, input bit v, input logic [7:0] d, input bit c);
        @(posedge clk);
        #1;
        msg_start  = s;
        msg_end    = e;
        rx_valid   = v;
        rx_data    = d;
        rx_corrupt = c;
    endtask

    task automatic quiet(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b0, 1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic start_msg();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic end_msg(input bit corrupt);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, corrupt);
    endtask

    initial begin
        int ok0;
        int err0;
        logic [7:0] ns_or_zero;

        #2 rst_n = 1'b0;
        #1;
        check("reset_regs", regs_flat, {FW{1'b0}});
        check("reset_cnt", FW'(err_count), FW'(8'h00));
        check("reset_ok", FW'(msg_ok), FW'(1'b0));
        check("reset_err", FW'(msg_err), FW'(1'b0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        quiet(2);

        // Good write
        ok0 = ok_seen;
        start_msg(); send(8'h82); send(8'hA5); send(8'h3C); end_msg(1'b0);
        quiet(3);
        check("good_reg2", FW'(reg_at(2)), FW'(8'hA5));
        check("good_reg3", FW'(reg_at(3)), FW'(8'h3C));
        check("good_reg0", FW'(reg_at(0)), FW'(8'h00));
        check("good_okcount", FW'(ok_seen - ok0), FW'(1));
        check("good_cnt", FW'(err_count), FW'(8'd0));

        // Bad command: write bit clear, then out-of-range address
        start_msg(); send(8'h02); send(8'h11); end_msg(1'b0);
        quiet(2);
        check("badcmd_cnt1", FW'(err_count), FW'(8'd1));
        check("badcmd_reg2", FW'(reg_at(2)), FW'(8'hA5));
        start_msg(); send(8'h90); send(8'h11); end_msg(1'b0);
        quiet(2);
        check("badaddr_cnt2", FW'(err_count), FW'(8'd2));

        // Overflow past the last register
        start_msg(); send(8'h8F); send(8'h01); send(8'h02); end_msg(1'b0);
        quiet(3);
`ifdef SPI_REG_SHADOW_EN
        ns_or_zero = 8'h00;
`else
        ns_or_zero = 8'h01;
`endif
        check("ovf_reg15", FW'(reg_at(15)), FW'(ns_or_zero));
        check("ovf_reg0", FW'(reg_at(0)), FW'(8'h00));
        check("ovf_cnt", FW'(err_count), FW'(8'd3));

        // Corrupt tail
        start_msg(); send(8'h80); send(8'h55); end_msg(1'b1);
        quiet(3);
`ifdef SPI_REG_SHADOW_EN
        ns_or_zero = 8'h00;
`else
        ns_or_zero = 8'h55;
`endif
        check("corrupt_reg0", FW'(reg_at(0)), FW'(ns_or_zero));
        check("corrupt_cnt", FW'(err_count), FW'(8'd4));

        // Lost end: second start aborts the first message
        ok0  = ok_seen;
        err0 = err_seen;
        start_msg(); send(8'h81); send(8'h77);
        start_msg(); send(8'h84); send(8'h99); end_msg(1'b0);
        quiet(3);
`ifdef SPI_REG_SHADOW_EN
        ns_or_zero = 8'h00;
`else
        ns_or_zero = 8'h77;
`endif
        check("lost_errpulses", FW'(err_seen - err0), FW'(1));
        check("lost_okpulses", FW'(ok_seen - ok0), FW'(1));
        check("lost_reg4", FW'(reg_at(4)), FW'(8'h99));
        check("lost_reg1", FW'(reg_at(1)), FW'(ns_or_zero));
        check("lost_cnt", FW'(err_count), FW'(8'd5));

        // Saturation with empty messages
        for (int i = 0; i < 260; i++) begin
            start_msg();
            end_msg(1'b0);
        end
        quiet(2);
        check("sat_cnt", FW'(err_count), FW'(8'd255));

        // Asynchronous reset in the middle of DATA
        start_msg(); send(8'h85); send(8'h12);
        @(posedge clk);
        #1;
        msg_start = 1'b0; msg_end = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_corrupt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_regs", regs_flat, {FW{1'b0}});
        check("arst_cnt", FW'(err_count), FW'(8'h00));
        check("arst_ok", FW'(msg_ok), FW'(1'b0));
        check("arst_err", FW'(msg_err), FW'(1'b0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        quiet(1);

        // Back-to-back bytes after reset, ending on the last register
        start_msg(); send(8'h8E); send(8'hAB); send(8'hCD); end_msg(1'b0);
        quiet(3);
        check("post_reg14", FW'(reg_at(14)), FW'(8'hAB));
        check("post_reg15", FW'(reg_at(15)), FW'(8'hCD));
        check("post_cnt", FW'(err_count), FW'(8'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_decoder.md
# spi_reg_decoder

Consumes the byte stream produced by the SPI slave receiver and turns each SPI message into writes to an NREGS x 8-bit control register bank. The bank's outputs drive the ToF driver's configuration inputs. Each message consists of a command/address byte followed by data bytes written at auto-incrementing addresses. Malformed messages are dropped and counted.

## Interface
Parameters:
- NREGS, 16, number of 8-bit registers; must be a power of two, 2..128.
- ADDR_W, $clog2(NREGS), register address width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- msg_start  in  1  one-cycle pulse: CSN fell.
- msg_end  in  1  one-cycle pulse: CSN rose.
- rx_data  in  8  received byte; qualified by rx_valid.
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete byte.
- rx_corrupt  in  1  level: partial byte in the current message; sampled only when msg_end=1.
- regs_flat  out  8*NREGS  live registers; register i is at [8*i+7:8*i].
- msg_ok  out  1  one-cycle pulse: message accepted.
- msg_err  out  1  one-cycle pulse: message dropped.
- err_count  out  8  saturating count of dropped messages.

## Operation
- **FSM states:** IDLE, CMD, DATA, DROP. The state holds its value unless a transition below applies.
- **IDLE:**
  - msg_start → CMD.
  - rx_valid and msg_end are ignored.
- **CMD:** on rx_valid, decode the command byte.
  - rx_data[7]=1 and rx_data[6:0] < NREGS: load addr = rx_data[ADDR_W-1:0], → DATA.
  - Otherwise (bit7=0, or address out of range): → DROP.
- **DATA:** on rx_valid, write rx_data to register addr, then increment addr.
  - If addr was NREGS-1 before the increment, the next rx_valid instead sets the overflow flag and goes → DROP.
  - There is no wrap-around.
- **msg_end handling:** applies in CMD, DATA and DROP; always → IDLE.
  - Message is good when: the state was DATA, rx_corrupt=0, and overflow=0.
  - Good message: pulse msg_ok.
  - Any other case: pulse msg_err and increment err_count.
  - A command-only message (msg_end while in CMD) is an error.
- **msg_start outside IDLE:** the previous message lost its msg_end.
  - Treat as an error for the old message: msg_err, err_count+1, discard its staged data.
  - Re-enter CMD for the new message.
- **Input priority within one cycle:** msg_start > msg_end > rx_valid. The lower-priority inputs are ignored that cycle.
- **err_count:** saturates at 255; never wraps.

## Timing
- **Reset values:** every output 0, state IDLE, addr 0, overflow 0.
- **rst_n:** asserting it mid-message returns the block to IDLE immediately and clears all registers.
- **Write latency:** a DATA-state rx_valid at edge N is visible on regs_flat after edge N+1, when SPI_REG_SHADOW_EN is undefined.
- **msg_ok / msg_err:** registered; asserted for exactly one cycle in the cycle after the msg_end (or aborting msg_start) is sampled.
- **rx_valid:** no ready/backpressure is needed. The block accepts one rx_valid per cycle, back to back.

## Configuration
- **SPI_REG_SHADOW_EN defined:**
  - DATA writes go to a shadow bank, plus a per-register dirty mask.
  - On a good msg_end, all dirty shadow entries are copied to the live registers in one cycle, visible the cycle after msg_end, together with msg_ok. The dirty mask is then cleared.
  - On an error or abort, the dirty mask is cleared and the live registers are unchanged.
  - Updates are therefore atomic per message.
- **SPI_REG_SHADOW_EN undefined:**
  - Writes go directly to the live registers.
  - A dropped message leaves any bytes already written in place; msg_err still pulses.

## Structure
- **spi_reg_pkg (shared package):**
  - FSM state encoding for IDLE, CMD, DATA, DROP.
  - CMD_WRITE_BIT = 7.
  - ERR_COUNT_MAX = 8'hFF.
- **spi_reg_bank (sub-module):**
  - Contents: live registers, the optional shadow bank and dirty mask, and the commit/discard logic.
  - Inputs: wr_en, wr_addr, wr_data, commit, discard.
  - Output: regs_flat.
- **spi_reg_decoder (top):** holds the FSM, address counter, overflow flag and error counter.

## Test plan
- **Good write:** start, bytes 0x82, 0xA5, 0x3C, end → reg2=0xA5, reg3=0x3C, all other registers 0; one msg_ok; err_count=0.
- **Bad command:**
  - Byte 0x02 (bit7=0) followed by 0x11 → registers unchanged, msg_err, err_count=1.
  - Repeat with address 0x90 when NREGS=16 → err_count=2.
- **Overflow:** start, 0x8F, 0x01, 0x02, end → reg15=0x01, msg_err, reg0 unchanged.
  - With SPI_REG_SHADOW_EN defined, reg15 also stays 0.
- **Corrupt tail:** start, 0x80, 0x55, then end with rx_corrupt=1.
  - Shadow build: reg0 stays 0.
  - Non-shadow build: reg0=0x55.
  - Both builds: msg_err.
- **Lost end:** start, 0x81, 0x77, then start, 0x84, 0x99, end.
  - Outputs: one msg_err, then one msg_ok; reg4=0x99.
  - reg1 = 0x00 in the shadow build, 0x77 in the non-shadow build.
- **Saturation and reset:**
  - 260 command-only messages → err_count=255.
  - Assert rst_n low mid-DATA → all outputs 0 on the same cycle, with no clock edge required.
